// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - Requester/CDB bundle between result producers and the CDB arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 16,
  parameter int TAG_W   = 3
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*WORD_W-1:0] req_value;
  logic [NUM_REQ-1:0]        gnt;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [WORD_W-1:0]         cdb_value;

  modport master (
    output req, req_tag, req_value,
    input  gnt, cdb_valid, cdb_tag, cdb_value
  );

  modport slave (
    input  req, req_tag, req_value,
    output gnt, cdb_valid, cdb_tag, cdb_value
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Round-robin common-data-bus arbiter with registered broadcast.
// CDB_LOAD_PRIORITY_EN: load buffer (last index) wins unless an ALU requester is starving.
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WORD_W       = 16,
  parameter int TAG_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int               PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   win_idx, idx;
  logic               win_vld;
  logic [NUM_REQ-1:0] grant;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [WORD_W-1:0]  cdb_value_q, cdb_value_d;

`ifdef CDB_LOAD_PRIORITY_EN
  localparam int               CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_q [NUM_REQ-1];
  logic [CNT_W-1:0] starve_d [NUM_REQ-1];
`endif

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = rr_q;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
`ifdef CDB_LOAD_PRIORITY_EN
    if (bus.req[NUM_REQ-1]) begin
      win_vld = 1'b1;
      win_idx = LAST;
    end
    // Descending scan so the lowest starving ALU index overrides last.
    for (int i = NUM_REQ - 2; i >= 0; i--) begin
      if (bus.req[i] && starve_q[i] == LIMIT) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
`endif
    if (flush || !rst_n) win_vld = 1'b0;
    grant = '0;
    if (win_vld) grant[win_idx] = 1'b1;
  end

  always_comb begin
    rr_d        = rr_q;
    cdb_valid_d = win_vld;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    if (win_vld) begin
      cdb_tag_d   = bus.req_tag[int'(win_idx)*TAG_W +: TAG_W];
      cdb_value_d = bus.req_value[int'(win_idx)*WORD_W +: WORD_W];
      if (win_idx != LAST) begin
        rr_d = win_idx + 1'b1;
      end else begin
`ifdef CDB_LOAD_PRIORITY_EN
        rr_d = rr_q;
`else
        rr_d = '0;
`endif
      end
    end
    if (flush) rr_d = '0;
  end

`ifdef CDB_LOAD_PRIORITY_EN
  always_comb begin
    for (int i = 0; i < NUM_REQ - 1; i++) begin
      if (flush || !bus.req[i] || grant[i]) starve_d[i] = '0;
      else if (starve_q[i] == LIMIT)        starve_d[i] = starve_q[i];
      else                                  starve_d[i] = starve_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ - 1; i++) starve_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ - 1; i++) starve_q[i] <= starve_d[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign bus.gnt       = grant;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_value = cdb_value_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - Self-checking bench for cdb_arbiter (table, corner sequences, random vs model).
module tb_cdb_arbiter;
  localparam int LIMIT = 4;

  logic clk;
  logic rst_n;
  logic flush4;
  logic flush3;

  cdb_arbiter_if #(.NUM_REQ(4), .WORD_W(16), .TAG_W(3)) bus4 ();
  cdb_arbiter_if #(.NUM_REQ(3), .WORD_W(16), .TAG_W(3)) bus3 ();

  cdb_arbiter #(.NUM_REQ(4), .WORD_W(16), .TAG_W(3), .STARVE_LIMIT(LIMIT)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .bus(bus4.slave));
  cdb_arbiter #(.NUM_REQ(3), .WORD_W(16), .TAG_W(3), .STARVE_LIMIT(LIMIT)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state for the 4-requester instance.
  int          m_rr;
  int          m_starve [4];
  logic        m_valid;
  logic [2:0]  m_tag;
  logic [15:0] m_val;

  typedef struct {
    logic [3:0]  req;
    logic        flush;
    logic [3:0]  gnt;
    logic        v;
    logic [2:0]  tag;
    logic [15:0] val;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int i = 0; i < 4; i++) m_starve[i] = 0;
    m_valid = 1'b0;
    m_tag   = '0;
    m_val   = '0;
  endtask

  function automatic int model_pick(input logic [3:0] r, input logic fl);
    if (fl) return -1;
`ifdef CDB_LOAD_PRIORITY_EN
    for (int i = 0; i < 3; i++) if (r[i] && m_starve[i] == LIMIT) return i;
    if (r[3]) return 3;
`endif
    for (int off = 0; off < 4; off++) begin
      int k;
      k = (m_rr + off) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_update(input int w, input logic [3:0] r, input logic fl,
                              input logic [11:0] tags, input logic [63:0] vals);
    for (int i = 0; i < 3; i++)
      m_starve[i] = (fl || !r[i] || w == i) ? 0 : ((m_starve[i] + 1 > LIMIT) ? LIMIT : m_starve[i] + 1);
    m_valid = (w >= 0);
    if (w >= 0) begin
      m_tag = tags[w*3 +: 3];
      m_val = vals[w*16 +: 16];
`ifdef CDB_LOAD_PRIORITY_EN
      if (w != 3) m_rr = (w + 1) % 4;
`else
      m_rr = (w + 1) % 4;
`endif
    end
    if (fl) m_rr = 0;
  endtask

  // One clock: compare against the model at the negedge, advance the model, then step past posedge.
  task automatic cycle(output logic [3:0] g, output logic [2:0] g3);
    int w;
    @(negedge clk);
    w  = model_pick(bus4.req, flush4);
    g  = bus4.gnt;
    g3 = bus3.gnt;
    chk("gnt_model", 32'(g), (w < 0) ? 32'd0 : (32'd1 << w));
    chk("cdb_valid_model", 32'(bus4.cdb_valid), 32'(m_valid));
    chk("cdb_tag_model", 32'(bus4.cdb_tag), 32'(m_tag));
    chk("cdb_value_model", 32'(bus4.cdb_value), 32'(m_val));
    model_update(w, bus4.req, flush4, bus4.req_tag, bus4.req_value);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  g;
    logic [2:0]  g3;
    logic [3:0]  pend;
    logic [11:0] rtag;
    logic [63:0] rval;

    tbl[0] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 3'd0, 16'h0000};
    tbl[1] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd5, 16'hBEEF};
    tbl[2] = '{4'b0101, 1'b1, 4'b0000, 1'b0, 3'd5, 16'hBEEF};
    tbl[3] = '{4'b0101, 1'b0, 4'b0001, 1'b0, 3'd5, 16'hBEEF};
    tbl[4] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 3'd1, 16'h1111};
    tbl[5] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 3'd2, 16'h2222};
    tbl[6] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 3'd1, 16'h1111};
    tbl[7] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'd5, 16'hBEEF};
    tbl[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 3'd5, 16'hBEEF};

    rst_n = 1'b0; flush4 = 1'b0; flush3 = 1'b0;
    bus4.req = '0; bus4.req_tag = '0; bus4.req_value = '0;
    bus3.req = '0; bus3.req_tag = '0; bus3.req_value = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus4.cdb_valid), 32'd0);
    chk("reset_tag", 32'(bus4.cdb_tag), 32'd0);
    chk("reset_value", 32'(bus4.cdb_value), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: single grant, hold on idle, flush priority, round-robin pointer movement.
    bus4.req_tag   = {3'd7, 3'd2, 3'd5, 3'd1};
    bus4.req_value = {16'h3333, 16'h2222, 16'hBEEF, 16'h1111};
    for (int i = 0; i < 9; i++) begin
      bus4.req = tbl[i].req;
      flush4   = tbl[i].flush;
      #1;
      chk($sformatf("tbl%0d_gnt", i), 32'(bus4.gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_valid", i), 32'(bus4.cdb_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_tag", i), 32'(bus4.cdb_tag), 32'(tbl[i].tag));
      chk($sformatf("tbl%0d_value", i), 32'(bus4.cdb_value), 32'(tbl[i].val));
      cycle(g, g3);
    end
    flush4 = 1'b0;

    // Asynchronous reset while a broadcast is on the bus and a request is pending.
    bus4.req = 4'b0001;
    cycle(g, g3);
    chk("pre_reset_valid", 32'(bus4.cdb_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(bus4.cdb_valid), 32'd0);
    chk("async_reset_tag", 32'(bus4.cdb_tag), 32'd0);
    chk("async_reset_value", 32'(bus4.cdb_value), 32'd0);
    chk("async_reset_gnt", 32'(bus4.gnt), 32'd0);
    bus4.req = '0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus4.req = 4'b0011;
    cycle(g, g3);
    chk("post_reset_rr0", 32'(g), 32'b0001);

    bus4.req = '0;
    flush4 = 1'b1;
    cycle(g, g3);
    flush4 = 1'b0;
`ifdef CDB_LOAD_PRIORITY_EN
    // Load held against req0: four load grants, then the starved ALU, repeating.
    bus4.req = 4'b1001;
    for (int c = 0; c < 10; c++) begin
      cycle(g, g3);
      chk($sformatf("loadprio_c%0d", c), 32'(g), (c % 5 == 4) ? 32'b0001 : 32'b1000);
    end
`else
    // All four requesting: strict rotation with back-to-back broadcasts.
    bus4.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      cycle(g, g3);
      chk($sformatf("rr_order_c%0d", c), 32'(g), 32'd1 << (c % 4));
      chk($sformatf("rr_valid_c%0d", c), 32'(bus4.cdb_valid), 32'd1);
    end
    bus4.req = '0;

    // Three requesters: pointer wraps from the last index back to 0.
    bus3.req_tag   = {3'd6, 3'd3, 3'd4};
    bus3.req_value = {16'hC0DE, 16'h0BB0, 16'h0AA0};
    bus3.req = 3'b010;
    cycle(g, g3);
    chk("n3_gnt1", 32'(g3), 32'b010);
    bus3.req = 3'b100;
    cycle(g, g3);
    chk("n3_gnt_last", 32'(g3), 32'b100);
    bus3.req = 3'b101;
    #1;
    chk("n3_cdb_valid", 32'(bus3.cdb_valid), 32'd1);
    chk("n3_cdb_tag", 32'(bus3.cdb_tag), 32'd6);
    chk("n3_cdb_value", 32'(bus3.cdb_value), 32'hC0DE);
    cycle(g, g3);
    chk("n3_wrap_gnt0", 32'(g3), 32'b001);
    bus3.req = '0;
`endif

    // Random traffic obeying the hold-until-granted handshake.
    bus4.req = '0;
    pend = '0;
    rtag = '0;
    rval = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          rtag[i*3 +: 3]   = 3'($urandom);
          rval[i*16 +: 16] = 16'($urandom);
        end
      end
      bus4.req       = pend;
      bus4.req_tag   = rtag;
      bus4.req_value = rval;
      flush4 = ($urandom_range(0, 15) == 0);
      cycle(g, g3);
      pend = pend & ~g;
    end
    bus4.req = '0;
    flush4 = 1'b0;
    cycle(g, g3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
